hgcal_input_packer: RTL and testbench
=====================================

# hgcal_input_packer

Upstream stage of the HGCal autoencoder layer-0 neuron array. Accepts a stream of raw per-cell sensor samples, one cell per beat. Quantizes each sample to the layer-0 activation width and packs one full frame into the flat activation vector that drives the layer-0 LUT neuron inputs. Holds the vector stable with a valid/ready handshake until the downstream registered stage takes it.

## Interface
Parameters:
- `N_FEAT`, 48: cells per frame, i.e. the width of the layer-0 input vector in features.
- `IN_W`, 10: raw sample width, unsigned.
- `Q_W`, 2: quantized activation width per feature.
- `SHIFT`, 6: right shift applied before saturation.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  packer accepts a sample.
- `s_data`  in  IN_W  raw sample.
- `s_last`  in  1  marks the final sample of a frame.
- `m_valid`  out  1  packed frame valid.
- `m_ready`  in  1  downstream accepts the frame.
- `m_data`  out  N_FEAT*Q_W  packed activations; feature i at bits [i*Q_W +: Q_W].
- `err_short`  out  1  one-cycle pulse: `s_last` arrived before N_FEAT samples.
- `err_long`  out  1  one-cycle pulse: N_FEAT samples arrived without `s_last`.

## Operation
- Quantize: q = min(s_data >> SHIFT, 2^Q_W−1). Unsigned arithmetic, saturating.
- Defaults give a maximum of 1023>>6 = 15, which saturates to 3.
- Feature index counter `idx` has width clog2(N_FEAT). A sample is accepted when `s_valid && s_ready`.
- FSM states: FILL, HOLD, DRAIN.
- FILL:
  - `s_ready`=1.
  - On accept, write q into slot `idx`.
  - If `s_last` and idx==N_FEAT−1: go to HOLD, set `m_valid`, idx←0.
  - If `s_last` and idx<N_FEAT−1: pulse `err_short`, idx←0, stay in FILL. The partial frame is discarded; stale slots are overwritten by the next frame.
  - If !`s_last` and idx==N_FEAT−1: pulse `err_long`, idx←0, go to DRAIN.
  - Otherwise: idx←idx+1.
- HOLD:
  - `s_ready`=0.
  - `m_valid`=1 and `m_data` stay stable until the cycle with `m_ready`=1.
  - After that handshake: `m_valid`←0, go to FILL.
- DRAIN:
  - `s_ready`=1.
  - Accepted samples are discarded.
  - An accepted beat with `s_last` returns the FSM to FILL, with no further error pulse.
- `m_data` is only updated by FILL writes, so it never changes while `m_valid`=1.
- Reset values:
  - state=FILL, idx=0.
  - `m_valid`=0, `m_data`=0.
  - `err_short`=`err_long`=0.
  - `s_ready`=1 from the first cycle after `rst_n` deasserts.
- Reset mid-frame or mid-HOLD: the frame is lost and `m_valid` drops immediately (asynchronous). No error pulse.

## Timing
- `m_valid` rises on the cycle after the edge that accepts the final in-range sample. Latency is 1 cycle from the last beat.
- Throughput: N_FEAT+1 cycles per frame when `m_ready` is held high. The one-cycle bubble is the HOLD state.
- `s_ready` is a pure function of registered state; there is no combinational path from `m_ready`.
- `err_*` are registered and assert the cycle after the offending beat.
- `m_valid`/`m_data` obey AXI-stream rules: once asserted, they are held until `m_ready`.

## Structure
- Shared package `hgcal_pkg`:
  - Constants `N_FEAT`, `IN_W`, `Q_W`, `SHIFT`.
  - FSM state enum `packer_state_t` (FILL, HOLD, DRAIN).
  - Function `quantize(sample)` returning Q_W bits.
- One natural sub-module: `hgcal_quantizer`, combinational shift-and-saturate, reused by later per-layer requantization.
- Top-level instantiates the packer in front of the layer-0 neuron array. `m_data` wires straight to the neuron input slices.

## Test plan
- Nominal frame: 48 beats of s_data=i*20 (i=0..47), `s_last` on beat 47, `m_ready`=1 → `m_valid` for 1 cycle, 1 cycle after beat 47.
  - Expected slot i = min((i*20)>>6, 3), e.g. slot 3 = 0, slot 4 = 1, slot 10 = 3.
- Backpressure: `m_ready`=0 for 10 cycles after the frame → `s_ready`=0 and `m_data` stable throughout.
  - Release → handshake, then `s_ready`=1 the next cycle.
- Short frame: `s_last` on beat 20 → `err_short` pulse, no `m_valid`.
  - The following 48-beat frame is packed correctly.
- Long frame: 52 beats with `s_last` on beat 51 → `err_long` pulse after beat 47, beats 48–51 dropped, no `m_valid`.
- Saturation: s_data=1023 and s_data=191 → slot values 3 and 2.
- Async reset asserted in HOLD with `m_valid`=1 → `m_valid`=0 immediately.
  - After release: idx=0, and the next full frame packs correctly.

Source files
------------

// File: rtl/hgcal_pkg.sv
// Shared constants, FSM state type and quantization helper for the HGCal layer-0 front end.
package hgcal_pkg;

  localparam int unsigned N_FEAT = 48;
  localparam int unsigned IN_W   = 10;
  localparam int unsigned Q_W    = 2;
  localparam int unsigned SHIFT  = 6;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } packer_state_t;

  // Shift-and-saturate of one raw sample to the activation width.
  function automatic logic [Q_W-1:0] quantize(input logic [IN_W-1:0] sample);
    logic [IN_W-1:0] shifted;
    shifted = sample >> SHIFT;
    if (shifted > IN_W'((1 << Q_W) - 1)) begin
      return Q_W'((1 << Q_W) - 1);
    end
    return Q_W'(shifted);
  endfunction

endpackage

// File: rtl/hgcal_quantizer.sv
// Combinational unsigned shift-and-saturate from a raw sample to a Q_W-bit activation.
module hgcal_quantizer #(
  parameter int unsigned IN_W  = hgcal_pkg::IN_W,
  parameter int unsigned Q_W   = hgcal_pkg::Q_W,
  parameter int unsigned SHIFT = hgcal_pkg::SHIFT
) (
  input  logic [IN_W-1:0] i_sample,
  output logic [Q_W-1:0]  o_q_c
);

  localparam logic [IN_W-1:0] QMAX = IN_W'((1 << Q_W) - 1);

  logic [IN_W-1:0] w_shift;

  assign w_shift = i_sample >> SHIFT;
  assign o_q_c   = (w_shift > QMAX) ? Q_W'(QMAX) : Q_W'(w_shift);

endmodule

// File: rtl/hgcal_input_packer.sv
// Packs one frame of quantized per-cell samples into the layer-0 activation vector,
// held with valid/ready until the downstream stage accepts it.
module hgcal_input_packer #(
  parameter int unsigned N_FEAT = hgcal_pkg::N_FEAT,
  parameter int unsigned IN_W   = hgcal_pkg::IN_W,
  parameter int unsigned Q_W    = hgcal_pkg::Q_W,
  parameter int unsigned SHIFT  = hgcal_pkg::SHIFT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_W-1:0]       s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [N_FEAT*Q_W-1:0] m_data,
  output logic                  err_short,
  output logic                  err_long
);

  import hgcal_pkg::*;

  localparam int unsigned IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int unsigned D_W   = N_FEAT * Q_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FEAT - 1);

  packer_state_t    r_state;
  packer_state_t    w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             r_m_valid;
  logic             w_m_valid_nxt;
  logic             r_err_short;
  logic             w_err_short_nxt;
  logic             r_err_long;
  logic             w_err_long_nxt;
  logic             r_s_ready;
  logic [D_W-1:0]   r_m_data;
  logic             w_accept;
  logic             w_wr_en;
  logic [Q_W-1:0]   w_q;

  hgcal_quantizer #(
    .IN_W  (IN_W),
    .Q_W   (Q_W),
    .SHIFT (SHIFT)
  ) u_quant (
    .i_sample (s_data),
    .o_q_c    (w_q)
  );

  assign w_accept = s_valid && r_s_ready;

  // Next-state, slot index, frame valid and error pulses.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_m_valid_nxt   = r_m_valid;
    w_err_short_nxt = 1'b0;
    w_err_long_nxt  = 1'b0;
    w_wr_en         = 1'b0;
    unique case (r_state)
      FILL: begin
        if (w_accept) begin
          w_wr_en = 1'b1;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt = '0;
            if (s_last) begin
              w_state_nxt   = HOLD;
              w_m_valid_nxt = 1'b1;
            end else begin
              w_state_nxt    = DRAIN;
              w_err_long_nxt = 1'b1;
            end
          end else if (s_last) begin
            w_idx_nxt       = '0;
            w_err_short_nxt = 1'b1;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (m_ready) begin
          w_state_nxt   = FILL;
          w_m_valid_nxt = 1'b0;
        end
      end
      DRAIN: begin
        if (w_accept && s_last) begin
          w_state_nxt = FILL;
        end
      end
      default: begin
        w_state_nxt = FILL;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // s_ready is registered alongside the state so it never depends on m_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FILL;
      r_idx       <= '0;
      r_m_valid   <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      r_s_ready   <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_m_valid   <= w_m_valid_nxt;
      r_err_short <= w_err_short_nxt;
      r_err_long  <= w_err_long_nxt;
      r_s_ready   <= (w_state_nxt != HOLD);
    end
  end

  // Slot writes happen only in FILL, so the vector is frozen while m_valid is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_data <= '0;
    end else if (w_wr_en) begin
      r_m_data[r_idx*Q_W +: Q_W] <= w_q;
    end
  end

  assign s_ready   = r_s_ready;
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign err_short = r_err_short;
  assign err_long  = r_err_long;

endmodule

// File: tb/tb_hgcal_input_packer.sv
// Randomized bench for hgcal_input_packer with a frame-level reference model and per-cycle compare.
module tb_hgcal_input_packer;

  localparam int N  = 48;
  localparam int QW = 2;
  localparam int DW = N * QW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [9:0]    s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          err_short;
  logic          err_long;

  int n_checks = 0;
  int n_pass   = 0;
  int n_mv     = 0;
  int n_el     = 0;
  int n_es     = 0;
  bit mr_rand  = 1'b0;

  // reference model state
  int            q_cur[$];
  logic [DW-1:0] e_frame = '0;
  bit            e_valid = 1'b0;
  bit            e_ready = 1'b1;
  bit            e_es    = 1'b0;
  bit            e_el    = 1'b0;
  bit            e_drop  = 1'b0;

  always #5 clk = ~clk;

  hgcal_input_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .err_short (err_short),
    .err_long  (err_long)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic int qm(input int x);
    int s;
    s = x / 64;
    return (s > 3) ? 3 : s;
  endfunction

  function automatic logic [1:0] slot(input logic [DW-1:0] v, input int i);
    return v[i*QW +: QW];
  endfunction

  // Frame-level model: collect quantized samples, decide frame / short / long on s_last.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q_cur.delete();
        e_valid = 1'b0;
        e_ready = 1'b1;
        e_es    = 1'b0;
        e_el    = 1'b0;
        e_drop  = 1'b0;
      end else begin
        e_es = 1'b0;
        e_el = 1'b0;
        if (e_valid) begin
          if (m_ready) e_valid = 1'b0;
        end else if (s_valid) begin
          if (e_drop) begin
            if (s_last) e_drop = 1'b0;
          end else begin
            q_cur.push_back(qm(int'(s_data)));
            if (q_cur.size() == N) begin
              if (s_last) begin
                for (int i = 0; i < N; i++) e_frame[i*QW +: QW] = QW'(q_cur[i]);
                e_valid = 1'b1;
              end else begin
                e_el   = 1'b1;
                e_drop = 1'b1;
              end
              q_cur.delete();
            end else if (s_last) begin
              e_es = 1'b1;
              q_cur.delete();
            end
          end
        end
        e_ready = !e_valid;
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("s_ready", s_ready, e_ready);
      chk("m_valid", m_valid, e_valid);
      chk("err_short", err_short, e_es);
      chk("err_long", err_long, e_el);
      if (e_valid) chk("m_data", m_data, e_frame);
      if (m_valid) n_mv++;
      if (err_long) n_el++;
      if (err_short) n_es++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mr_rand) m_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input int d, input bit last);
    int g;
    g = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 10'(d);
    s_last  = last;
    while (!s_ready && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) begin
      n_checks++;
      $display("FAIL send_timeout: s_ready stayed 0 for %0d cycles expected 1", g);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 10'($urandom_range(0, 1023));
    end
  endtask

  task automatic send_frame(input int len, input bit gaps);
    for (int i = 0; i < len; i++) begin
      send(int'($urandom_range(0, 1023)), i == len - 1);
      if (gaps && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
  endtask

  initial begin
    logic [DW-1:0] snap;
    m_ready = 1'b1;
    @(negedge clk);
    chk("reset_m_valid", m_valid, 1'b0);
    chk("reset_m_data", m_data, '0);
    chk("reset_errs", {err_short, err_long}, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_s_ready", s_ready, 1'b1);

    // nominal ramp frame
    for (int i = 0; i < N; i++) send(i * 20, i == N - 1);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    snap = m_data;
    chk("nom_valid", m_valid, 1'b1);
    chk("nom_slot3", slot(snap, 3), 2'd0);
    chk("nom_slot4", slot(snap, 4), 2'd1);
    chk("nom_slot10", slot(snap, 10), 2'd3);
    chk("nom_slot47", slot(snap, 47), 2'd3);
    @(negedge clk);
    chk("nom_valid_one_cycle", m_valid, 1'b0);
    chk("nom_ready_back", s_ready, 1'b1);

    // backpressure
    m_ready = 1'b0;
    send_frame(N, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    snap = m_data;
    chk("bp_valid", m_valid, 1'b1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_s_ready_low", s_ready, 1'b0);
      chk("bp_data_stable", m_data, snap);
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp_released_valid", m_valid, 1'b0);
    chk("bp_released_ready", s_ready, 1'b1);

    // short frame then a clean frame
    n_mv = 0;
    n_es = 0;
    send_frame(21, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("short_err_pulse", err_short, 1'b1);
    chk("short_no_valid", m_valid, 1'b0);
    @(negedge clk);
    chk("short_err_one_cycle", err_short, 1'b0);
    chk("short_pulse_count", n_es, 1);
    send_frame(N, 1'b0);
    idle(2);
    chk("after_short_frame_count", n_mv, 1);

    // long frame
    n_mv = 0;
    n_el = 0;
    send_frame(52, 1'b0);
    idle(3);
    chk("long_err_count", n_el, 1);
    chk("long_no_valid", n_mv, 0);
    send_frame(N, 1'b0);
    idle(2);

    // saturation
    for (int i = 0; i < N; i++)
      send((i == 0) ? 1023 : (i == 1) ? 191 : int'($urandom_range(0, 1023)), i == N - 1);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("sat_slot0", slot(m_data, 0), 2'd3);
    chk("sat_slot1", slot(m_data, 1), 2'd2);
    idle(2);

    // async reset while holding a frame
    m_ready = 1'b0;
    send_frame(N, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("hold_before_reset", m_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_in_hold_valid", m_valid, 1'b0);
    chk("reset_in_hold_ready", s_ready, 1'b1);
    @(negedge clk);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < N; i++) send(i * 20, i == N - 1);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("after_reset_valid", m_valid, 1'b1);
    chk("after_reset_slot4", slot(m_data, 4), 2'd1);
    chk("after_reset_slot3", slot(m_data, 3), 2'd0);
    idle(2);

    // randomized frames with gaps and random backpressure
    mr_rand = 1'b1;
    for (int f = 0; f < 25; f++) begin
      int kind;
      int len;
      kind = int'($urandom_range(0, 9));
      if (kind < 7) len = N;
      else if (kind < 9) len = int'($urandom_range(1, N - 1));
      else len = int'($urandom_range(N + 1, N + 8));
      send_frame(len, 1'b1);
    end
    idle(1);
    mr_rand = 1'b0;
    m_ready = 1'b1;
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
